// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC sample sequencer.
//   seq_state_t : sequencer FSM states
//   ACC_EXTRA   : accumulator headroom bits (up to 2^7 samples per window)
//   ACC_W       : accumulator width for the default 12-bit converter
//   DEF_TIMEOUT : default soc-to-eoc abort limit in clk cycles
package adc_seq_pkg;

  localparam int unsigned DEF_SIZE    = 12;
  localparam int unsigned ACC_EXTRA   = 7;
  localparam int unsigned ACC_W       = DEF_SIZE + ACC_EXTRA;
  localparam int unsigned SMP_W       = ACC_EXTRA + 1;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    CONVERT = 2'd2,
    WAIT    = 2'd3
  } seq_state_t;

  // Accumulator width for an arbitrary converter width.
  function automatic int unsigned acc_w(input int unsigned size);
    return size + ACC_EXTRA;
  endfunction

endpackage

// File: rtl/adc_result_fifo.sv
// Shift-register result FIFO; entry 0 is always the head so head_data is a flop.
//   clk, rst    : clock, async active-high reset
//   push        : write push_data (accepted when not full, or full with pop)
//   pop         : remove head (ignored when empty)
//   full, empty : registered occupancy flags
//   head_valid  : registered "not empty"
//   head_data   : registered head entry
module adc_result_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] ent     [DEPTH];
  logic [WIDTH-1:0] ent_nxt [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] wr_idx;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok    = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_ok   = push & (~full | pop_ok);
  assign wr_idx    = IDX_W'(cnt - CNT_W'(pop_ok));
  assign cnt_nxt   = cnt - CNT_W'(pop_ok) + CNT_W'(push_ok);
  assign head_data = ent[0];

  // Next contents: shift toward the head on pop, then write at the new tail.
  always_comb begin
    ent_nxt = ent;
    if (pop_ok) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) ent_nxt[i] = ent[i + 1];
    end
    if (push_ok) ent_nxt[wr_idx] = push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
      cnt        <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      head_valid <= 1'b0;
    end else begin
      ent        <= ent_nxt;
      cnt        <= cnt_nxt;
      full       <= (cnt_nxt == CNT_W'(DEPTH));
      empty      <= (cnt_nxt == '0);
      head_valid <= (cnt_nxt != '0);
    end
  end

endmodule

// File: rtl/adc_sample_sequencer.sv
// ADC sample sequencer: periodic soc pulses to the SAR controller, eoc capture,
// 2^osr_log2 oversampling average, result FIFO, timeout/overflow sticky flags.
// Optional macro ADC_SEQ_ROUND_EN: round-half-up average (saturated) instead
// of truncation.
//   clk, rst             : clock, async active-high reset
//   enable               : run sequencer
//   period               : soc-to-soc spacing in cycles (0 = back-to-back)
//   osr_log2             : log2 of samples averaged per result
//   soc / eoc / adc_data : SAR controller handshake and result
//   res_data / res_valid / res_ready : averaged result stream (FIFO head)
//   overflow, timeout_err, err_clr   : sticky error flags and their clear
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned SIZE       = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [15:0]     period,
  input  logic [2:0]      osr_log2,
  output logic            soc,
  input  logic            eoc,
  input  logic [SIZE-1:0] adc_data,
  output logic [SIZE-1:0] res_data,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            overflow,
  output logic            timeout_err,
  input  logic            err_clr
);

  localparam int unsigned AW    = acc_w(SIZE);
  localparam int unsigned SUM_W = AW + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  seq_state_t       state;
  logic             eoc_q;
  logic [15:0]      ptmr;
  logic [TMO_W-1:0] tmo;
  logic [AW-1:0]    acc;
  logic [SMP_W-1:0] smp_cnt;
  logic [2:0]       osr_win;

  logic             capture;
  logic [2:0]       osr_eff;
  logic [SUM_W-1:0] sum;
  logic             win_done;
  logic [SIZE-1:0]  avg;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  logic             tmo_evt;

  assign capture  = eoc & ~eoc_q;
  // The window's ratio is frozen by its first sample.
  assign osr_eff  = (smp_cnt == '0) ? osr_log2 : osr_win;
  assign sum      = SUM_W'(acc) + SUM_W'(adc_data);
  assign win_done = (smp_cnt + SMP_W'(1)) == (SMP_W'(1) << osr_eff);

`ifdef ADC_SEQ_ROUND_EN
  logic [SUM_W-1:0] rnd;
  logic [SUM_W-1:0] shifted;
  assign rnd     = (SUM_W'(1) << osr_eff) >> 1;
  assign shifted = (sum + rnd) >> osr_eff;
  assign avg     = (shifted > SUM_W'({SIZE{1'b1}})) ? {SIZE{1'b1}} : SIZE'(shifted);
`else
  assign avg     = SIZE'(sum >> osr_eff);
`endif

  assign push    = (state == CONVERT) & capture & enable & win_done;
  assign pop     = res_valid & res_ready & ~fifo_empty;
  assign drop    = push & fifo_full & ~pop;
  assign tmo_evt = (state == CONVERT) & ~capture & (tmo == '0);

  // Sequencer FSM, timers, accumulator and sticky flags. START and the
  // registered WAIT->START decision each use a cycle, so both timers are
  // loaded with N-2 and read 0 on the last cycle of their interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      soc         <= 1'b0;
      eoc_q       <= 1'b0;
      ptmr        <= '0;
      tmo         <= '0;
      acc         <= '0;
      smp_cnt     <= '0;
      osr_win     <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      eoc_q       <= eoc;
      osr_win     <= osr_eff;
      soc         <= 1'b0;
      overflow    <= drop    | (overflow    & ~err_clr);
      timeout_err <= tmo_evt | (timeout_err & ~err_clr);
      case (state)
        IDLE: begin
          if (enable) begin
            state <= START;
            soc   <= 1'b1;
          end
        end
        START: begin
          ptmr  <= (period > 16'd2) ? period - 16'd2 : 16'd0;
          tmo   <= TMO_W'(TIMEOUT - 2);
          state <= CONVERT;
        end
        CONVERT: begin
          ptmr <= (ptmr != '0) ? ptmr - 16'd1 : 16'd0;
          tmo  <= (tmo  != '0) ? tmo  - TMO_W'(1) : '0;
          if (capture) begin
            if (!enable || win_done) begin
              acc     <= '0;
              smp_cnt <= '0;
            end else begin
              acc     <= AW'(sum);
              smp_cnt <= smp_cnt + SMP_W'(1);
            end
            state <= enable ? WAIT : IDLE;
          end else if (tmo == '0) begin
            acc     <= '0;
            smp_cnt <= '0;
            state   <= enable ? WAIT : IDLE;
          end
        end
        WAIT: begin
          ptmr <= (ptmr != '0) ? ptmr - 16'd1 : 16'd0;
          if (ptmr == '0) begin
            if (enable) begin
              state <= START;
              soc   <= 1'b1;
            end else begin
              state   <= IDLE;
              acc     <= '0;
              smp_cnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  adc_result_fifo #(
    .WIDTH (SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (avg),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (res_valid),
    .head_data  (res_data)
  );

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Self-checking bench for adc_sample_sequencer with a SAR controller model
// and a queue of expected averaged results.
module tb_adc_sample_sequencer;

  localparam int unsigned SIZE = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [15:0]     period;
  logic [2:0]      osr_log2;
  logic            soc;
  logic            eoc;
  logic [SIZE-1:0] adc_data;
  logic [SIZE-1:0] res_data;
  logic            res_valid;
  logic            res_ready;
  logic            overflow;
  logic            timeout_err;
  logic            err_clr;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  logic [SIZE-1:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_sample_sequencer #(.SIZE(SIZE), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .osr_log2(osr_log2),
    .soc(soc), .eoc(eoc), .adc_data(adc_data), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .overflow(overflow),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  // Reference average of a completed window.
  function automatic logic [SIZE-1:0] model_avg(input int s, input int osr);
    int r;
`ifdef ADC_SEQ_ROUND_EN
    r = (s + ((1 << osr) >> 1)) >> osr;
    if (r > 4095) r = 4095;
`else
    r = s >> osr;
`endif
    return SIZE'(r);
  endfunction

  // SAR model: wait for soc, answer lat cycles later with a 1-cycle eoc.
  // Returns at the cycle after the capture cycle.
  task automatic do_conv(input logic [SIZE-1:0] d, input int lat, output int t_soc,
                         output logic soc_nxt, output logic rv_cap);
    logic found;
    found = 1'b0; t_soc = -1; soc_nxt = 1'bx; rv_cap = 1'bx;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (soc === 1'b1) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL soc_wait: soc not seen within 400 cycles (want a pulse)");
    end else begin
      t_soc = cyc;
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        if (k == 0) soc_nxt = soc;
      end
      rv_cap = res_valid;
      adc_data = d; eoc = 1'b1;
      @(negedge clk);
      eoc = 1'b0;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++; if (soc !== 1'b0)         begin miscompares++; $display("FAIL reset_soc: got %b want 0", soc); end
    vectors++; if (res_valid !== 1'b0)   begin miscompares++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    vectors++; if (res_data !== '0)      begin miscompares++; $display("FAIL reset_data: got %h want 000", res_data); end
    vectors++; if (overflow !== 1'b0)    begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
    rst = 1'b0;
    settle(2);
  endtask

  task automatic test_basic;
    logic [SIZE-1:0] d [3];
    int t, t_prev;
    logic sn, rv;
    logic [SIZE-1:0] e;
    d[0] = 12'hA5C; d[1] = 12'h123; d[2] = 12'hFFF;
    period = 16'd10; osr_log2 = 3'd0; res_ready = 1'b1; enable = 1'b1;
    t_prev = -1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model_avg(int'(d[i]), 0));
      do_conv(d[i], 5, t, sn, rv);
      if (i == 2) enable = 1'b0;
      vectors++; if (sn !== 1'b0) begin miscompares++; $display("FAIL basic_soc_width: soc at soc+1 got %b want 0", sn); end
      vectors++; if (rv !== 1'b0) begin miscompares++; $display("FAIL basic_valid_early: got %b want 0", rv); end
      e = exp_q.pop_front();
      vectors++; if (res_valid !== 1'b1 || res_data !== e) begin
        miscompares++; $display("FAIL basic_result: got v=%b d=%h want v=1 d=%h", res_valid, res_data, e); end
      if (t_prev >= 0) begin
        vectors++; if (t - t_prev !== 10) begin miscompares++; $display("FAIL basic_period: got %0d want 10", t - t_prev); end
      end
      t_prev = t;
    end
    settle(20);
  endtask

  task automatic test_oversample;
    int t, s;
    logic sn, rv;
    logic [SIZE-1:0] e;
    period = 16'd10; osr_log2 = 3'd2; res_ready = 1'b1; enable = 1'b1;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      s += 100 + i;
      if (i == 3) exp_q.push_back(model_avg(s, 2));
      do_conv(SIZE'(100 + i), 5, t, sn, rv);
      if (i < 3) begin
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL osr_partial: sample %0d got v=%b want 0", i, res_valid); end
      end else begin
        e = exp_q.pop_front();
        vectors++; if (res_valid !== 1'b1 || res_data !== e) begin
          miscompares++; $display("FAIL osr_avg: got v=%b d=%0d want v=1 d=%0d", res_valid, res_data, e); end
      end
    end
    // Ratio changed mid-window must wait for the next window.
    osr_log2 = 3'd1;
    do_conv(12'd10, 5, t, sn, rv);
    osr_log2 = 3'd0;
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL osr_midwin: got v=%b want 0", res_valid); end
    exp_q.push_back(model_avg(31, 1));
    do_conv(12'd21, 5, t, sn, rv);
    enable = 1'b0;
    e = exp_q.pop_front();
    vectors++; if (res_valid !== 1'b1 || res_data !== e) begin
      miscompares++; $display("FAIL osr_midwin_avg: got v=%b d=%0d want v=1 d=%0d", res_valid, res_data, e); end
    settle(20);
  endtask

  task automatic test_overflow;
    int t, n;
    logic sn, rv;
    logic [SIZE-1:0] d, e;
    period = 16'd10; osr_log2 = 3'd0; res_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = SIZE'(12'h100 + i * 12'h011);
      if (i < 4) exp_q.push_back(model_avg(int'(d), 0));
      do_conv(d, 5, t, sn, rv);
      if (i == 5) enable = 1'b0;
      vectors++; if (overflow !== (i >= 4)) begin
        miscompares++; $display("FAIL ovf_flag: after conv %0d got %b want %b", i + 1, overflow, i >= 4); end
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n++;
        vectors++; if (res_data !== e) begin miscompares++; $display("FAIL ovf_order: entry %0d got %h want %h", n, res_data, e); end
      end
      res_ready = 1'b1;
    end
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL ovf_count: got %0d entries want 4", n); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_drained: got v=%b want 0", res_valid); end
    settle(10);
  endtask

  task automatic test_timeout;
    int t0, t1, t2;
    logic found, sn, rv;
    logic [SIZE-1:0] e;
    period = 16'd80; osr_log2 = 3'd0; res_ready = 1'b1; enable = 1'b1;
    found = 1'b0; t0 = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (soc === 1'b1) begin found = 1'b1; t0 = cyc; end
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL tmo_soc: soc not seen (want a pulse)"); end
    found = 1'b0; t1 = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin found = 1'b1; t1 = cyc; end
    end
    vectors++; if (!found || t1 - t0 !== 64) begin
      miscompares++; $display("FAIL tmo_latency: got found=%b delay=%0d want delay 64", found, t1 - t0); end
    exp_q.push_back(model_avg(12'h3C3, 0));
    do_conv(12'h3C3, 5, t2, sn, rv);
    enable = 1'b0;
    vectors++; if (t2 - t0 !== 80) begin miscompares++; $display("FAIL tmo_next_soc: got %0d want 80", t2 - t0); end
    e = exp_q.pop_front();
    vectors++; if (res_valid !== 1'b1 || res_data !== e) begin
      miscompares++; $display("FAIL tmo_resume: got v=%b d=%h want v=1 d=%h", res_valid, res_data, e); end
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_clear: got %b want 0", timeout_err); end
    settle(90);
  endtask

  task automatic test_back_to_back;
    int t, t_prev;
    logic sn, rv;
    logic [SIZE-1:0] e;
    period = 16'd0; osr_log2 = 3'd0; res_ready = 1'b1; enable = 1'b1;
    t_prev = -1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model_avg(40 + i, 0));
      do_conv(SIZE'(40 + i), 8, t, sn, rv);
      if (i == 2) enable = 1'b0;
      e = exp_q.pop_front();
      vectors++; if (res_valid !== 1'b1 || res_data !== e) begin
        miscompares++; $display("FAIL b2b_result: got v=%b d=%0d want v=1 d=%0d", res_valid, res_data, e); end
      // capture at soc+8, one WAIT cycle, next soc two cycles after capture
      if (t_prev >= 0) begin
        vectors++; if (t - t_prev !== 10) begin miscompares++; $display("FAIL b2b_spacing: got %0d want 10", t - t_prev); end
      end
      t_prev = t;
    end
    settle(10);
  endtask

  task automatic test_enable_drop;
    int t, n_soc, n_val;
    logic found, sn, rv;
    logic [SIZE-1:0] e;
    period = 16'd20; osr_log2 = 3'd1; res_ready = 1'b1; enable = 1'b1;
    do_conv(12'h111, 5, t, sn, rv);
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL drop_first: got v=%b want 0", res_valid); end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (soc === 1'b1) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL drop_soc: soc not seen (want a pulse)"); end
    settle(2);
    enable = 1'b0;
    settle(3);
    adc_data = 12'h7FF; eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    n_soc = 0; n_val = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (soc !== 1'b0) n_soc++;
      if (res_valid !== 1'b0) n_val++;
    end
    vectors++; if (n_soc !== 0) begin miscompares++; $display("FAIL drop_idle_soc: got %0d soc cycles want 0", n_soc); end
    vectors++; if (n_val !== 0) begin miscompares++; $display("FAIL drop_no_push: got %0d valid cycles want 0", n_val); end
    // A fresh window must not contain the abandoned sample.
    enable = 1'b1;
    do_conv(12'h200, 5, t, sn, rv);
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL drop_fresh_partial: got v=%b want 0", res_valid); end
    exp_q.push_back(model_avg(12'h500, 1));
    do_conv(12'h300, 5, t, sn, rv);
    enable = 1'b0;
    e = exp_q.pop_front();
    vectors++; if (res_valid !== 1'b1 || res_data !== e) begin
      miscompares++; $display("FAIL drop_fresh_avg: got v=%b d=%h want v=1 d=%h", res_valid, res_data, e); end
    settle(30);
  endtask

  task automatic test_async_reset;
    int t;
    logic found, sn, rv;
    period = 16'd10; osr_log2 = 3'd0; res_ready = 1'b0; enable = 1'b1;
    do_conv(12'h5A5, 5, t, sn, rv);
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL arst_pre: got v=%b want 1", res_valid); end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (soc === 1'b1) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL arst_soc: soc not seen (want a pulse)"); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (soc !== 1'b0)         begin miscompares++; $display("FAIL arst_soc_drop: got %b want 0", soc); end
    vectors++; if (res_valid !== 1'b0)   begin miscompares++; $display("FAIL arst_valid: got %b want 0", res_valid); end
    vectors++; if (res_data !== '0)      begin miscompares++; $display("FAIL arst_data: got %h want 000", res_data); end
    vectors++; if (overflow !== 1'b0)    begin miscompares++; $display("FAIL arst_ovf: got %b want 0", overflow); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL arst_tmo: got %b want 0", timeout_err); end
    @(negedge clk);
    enable = 1'b0; rst = 1'b0;
    exp_q.delete();
    settle(5);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; period = '0; osr_log2 = '0; eoc = 1'b0;
    adc_data = '0; res_ready = 1'b0; err_clr = 1'b0;
    test_reset();
    test_basic();
    test_oversample();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
